dma_desc_scheduler: RTL and testbench

- Sequences the dma_func_wrapper engine on behalf of two descriptor requesters (port 0 = host CSR path, port 1 = accelerator path).
- Buffers descriptors per requester, arbitrates round-robin, pulses dma_go, and holds the descriptor stable until done or timeout.
- Reports one completion record per descriptor.
- Drives master_ctrl of the AXI Multiplexer so the DMA owns memory only while a transfer is in flight.

---
 rtl/dma_desc_scheduler_pkg.sv | 48 ++++
 rtl/dma_desc_fifo.sv | 57 +++++
 rtl/dma_desc_scheduler.sv | 169 ++++++++++++++++
 tb/tb_dma_desc_scheduler.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_desc_scheduler_pkg.sv
// Shared types for the DMA descriptor scheduler: descriptor, DMA status/error,
// completion record, scheduler state encoding and the round-robin pick helper.
package dma_desc_scheduler_pkg;

    localparam int SCHED_NUM_REQ = 2;

    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [31:0] num_bytes;
    } s_dma_desc_t;

    typedef struct packed {
        logic busy;
        logic done;
    } s_dma_status_t;

    typedef struct packed {
        logic [31:0] err_addr;
        logic        err_src;
        logic        err_dst;
    } s_dma_error_t;

    typedef struct packed {
        logic         req_id;
        logic         err;
        logic         timeout;
        logic         skipped;
        s_dma_error_t dma_err;
    } s_dma_sched_cpl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GO   = 2'd1,
        WAIT = 2'd2,
        CPL  = 2'd3
    } e_dma_sched_state_t;

    // Pointer wins when its FIFO has data; otherwise the other requester wins.
    function automatic logic rr_pick(input logic [SCHED_NUM_REQ-1:0] nonempty,
                                     input logic ptr);
        if (nonempty[ptr]) begin
            return ptr;
        end
        return ~ptr;
    endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO with a combinational head (no read latency).
// Push must only be asserted when not full, pop only when not empty.
module dma_desc_fifo
    import dma_desc_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  s_dma_desc_t din,
    output s_dma_desc_t head,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    s_dma_desc_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    assign head  = mem[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    // Pointer and occupancy tracking; push+pop together leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Descriptor storage, written at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/dma_desc_scheduler.sv
// Two-requester DMA descriptor scheduler: buffers descriptors, arbitrates
// round-robin, launches the DMA, supervises completion/timeout and reports
// one completion record per descriptor.
module dma_desc_scheduler
    import dma_desc_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en_i,
    input  logic [SCHED_NUM_REQ-1:0]             req_valid_i,
    output logic [SCHED_NUM_REQ-1:0]             req_ready_o,
    input  s_dma_desc_t [SCHED_NUM_REQ-1:0]      req_desc_i,
    output logic                                 dma_go_o,
    output s_dma_desc_t                          dma_desc_o,
    input  s_dma_status_t                        dma_stats_i,
    input  s_dma_error_t                         dma_error_i,
    output logic                                 master_ctrl_o,
    output logic                                 cpl_valid_o,
    input  logic                                 cpl_ready_i,
    output s_dma_sched_cpl_t                     cpl_o,
    output logic                                 busy_o
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    e_dma_sched_state_t              state_q;
    e_dma_sched_state_t              state_d;
    logic [SCHED_NUM_REQ-1:0]        fifo_full;
    logic [SCHED_NUM_REQ-1:0]        fifo_empty;
    logic [SCHED_NUM_REQ-1:0]        fifo_push;
    logic [SCHED_NUM_REQ-1:0]        fifo_pop;
    s_dma_desc_t [SCHED_NUM_REQ-1:0] fifo_head;
    logic                            ready_en_q;
    logic                            rr_ptr_q;
    logic                            grant_id;
    logic                            grant_vld;
    logic                            grant_skip;
    logic                            wait_done;
    logic                            wait_to;
    logic                            to_hit;
    logic [CNT_W-1:0]                cnt_q;
    logic                            unused_stats;

    assign unused_stats = dma_stats_i.busy;

    // Ready is held low through reset and only reflects FIFO space afterwards.
    assign req_ready_o = {SCHED_NUM_REQ{ready_en_q}} & ~fifo_full;
    assign fifo_push   = req_valid_i & req_ready_o;
    assign grant_id    = rr_pick(~fifo_empty, rr_ptr_q);
    assign to_hit      = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    for (genvar g = 0; g < SCHED_NUM_REQ; g++) begin : g_fifo
        dma_desc_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (fifo_push[g]),
            .pop   (fifo_pop[g]),
            .din   (req_desc_i[g]),
            .head  (fifo_head[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    // Enables the ready outputs one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, launch/completion strobes and state-decoded outputs.
    always_comb begin
        state_d       = state_q;
        fifo_pop      = '0;
        grant_vld     = 1'b0;
        grant_skip    = 1'b0;
        wait_done     = 1'b0;
        wait_to       = 1'b0;
        dma_go_o      = 1'b0;
        master_ctrl_o = 1'b0;
        cpl_valid_o   = 1'b0;
        busy_o        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (en_i && (|(~fifo_empty))) begin
                    grant_vld          = 1'b1;
                    fifo_pop[grant_id] = 1'b1;
                    if (fifo_head[grant_id].num_bytes == '0) begin
                        grant_skip = 1'b1;
                        state_d    = CPL;
                    end else begin
                        state_d = GO;
                    end
                end
            end
            GO: begin
                dma_go_o      = 1'b1;
                master_ctrl_o = 1'b1;
                state_d       = WAIT;
            end
            WAIT: begin
                master_ctrl_o = 1'b1;
                if (dma_stats_i.done) begin
                    wait_done = 1'b1;
                    state_d   = CPL;
                end else if (to_hit) begin
                    wait_to = 1'b1;
                    state_d = CPL;
                end
            end
            CPL: begin
                cpl_valid_o = 1'b1;
                if (cpl_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Descriptor latch, RR pointer, WAIT counter and completion record build-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= 1'b0;
            cnt_q      <= '0;
            dma_desc_o <= '0;
            cpl_o      <= '0;
        end else begin
            if (grant_vld) begin
                rr_ptr_q      <= ~grant_id;
                dma_desc_o    <= fifo_head[grant_id];
                cpl_o         <= '0;
                cpl_o.req_id  <= grant_id;
                cpl_o.skipped <= grant_skip;
            end
            if (state_q == GO) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (wait_done) begin
                cpl_o.err     <= |dma_error_i;
                cpl_o.dma_err <= dma_error_i;
            end
            if (wait_to) begin
                cpl_o.timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_desc_scheduler.sv
// Directed self-checking bench for dma_desc_scheduler. A second instance with a
// short timeout covers the timeout path; a simple DMA model raises done a
// programmable number of cycles after each go pulse (0 = never).
module tb_dma_desc_scheduler;
    import dma_desc_scheduler_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              cpl_ready;
    logic              to_cpl_ready;
    logic [1:0]        req_valid;
    logic [1:0]        to_req_valid;
    s_dma_desc_t [1:0] req_desc;
    s_dma_status_t     stats = '0;
    s_dma_error_t      dma_err_in;

    logic [1:0]        ready;
    logic              go;
    s_dma_desc_t       desc_out;
    logic              mctrl;
    logic              cpl_valid;
    s_dma_sched_cpl_t  cpl;
    logic              busy;

    logic [1:0]        to_ready;
    logic              to_go;
    s_dma_desc_t       to_desc_out;
    logic              to_mctrl;
    logic              to_cpl_valid;
    s_dma_sched_cpl_t  to_cpl;
    logic              to_busy;

    int compared   = 0;
    int mismatched = 0;
    int done_delay = 0;
    int dcnt       = 0;
    bit dact       = 0;

    dma_desc_scheduler #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (4096),
        .CNT_W          (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en),
        .req_valid_i   (req_valid),
        .req_ready_o   (ready),
        .req_desc_i    (req_desc),
        .dma_go_o      (go),
        .dma_desc_o    (desc_out),
        .dma_stats_i   (stats),
        .dma_error_i   (dma_err_in),
        .master_ctrl_o (mctrl),
        .cpl_valid_o   (cpl_valid),
        .cpl_ready_i   (cpl_ready),
        .cpl_o         (cpl),
        .busy_o        (busy)
    );

    dma_desc_scheduler #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (16)
    ) dut_to (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en),
        .req_valid_i   (to_req_valid),
        .req_ready_o   (to_ready),
        .req_desc_i    (req_desc),
        .dma_go_o      (to_go),
        .dma_desc_o    (to_desc_out),
        .dma_stats_i   (stats),
        .dma_error_i   (dma_err_in),
        .master_ctrl_o (to_mctrl),
        .cpl_valid_o   (to_cpl_valid),
        .cpl_ready_i   (to_cpl_ready),
        .cpl_o         (to_cpl),
        .busy_o        (to_busy)
    );

    always #5 clk = ~clk;

    // DMA model: done drops on go and rises done_delay cycles later.
    always @(negedge clk) begin
        if (!rst_n) begin
            stats.done = 1'b0;
            dact       = 1'b0;
        end else if (go || to_go) begin
            stats.done = 1'b0;
            dcnt       = 0;
            dact       = (done_delay != 0);
        end else if (dact) begin
            dcnt = dcnt + 1;
            if (dcnt == done_delay) begin
                stats.done = 1'b1;
                dact       = 1'b0;
            end
        end
    end

    function automatic s_dma_desc_t mk(input logic [31:0] s, input logic [31:0] d,
                                       input logic [31:0] n);
        s_dma_desc_t r;
        r.src_addr  = s;
        r.dst_addr  = d;
        r.num_bytes = n;
        return r;
    endfunction

    function automatic logic sel(input int which);
        case (which)
            0:       return go;
            1:       return cpl_valid;
            2:       return to_go;
            default: return to_cpl_valid;
        endcase
    endfunction

    // Waits (at negedges) for the selected signal; cyc = -1 when the bound expires.
    task automatic wait_for(input int which, input int limit, output int cyc);
        cyc = -1;
        for (int i = 0; i < limit; i++) begin
            if (sel(which)) begin
                cyc = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Presents a descriptor until accepted; returns at the negedge after acceptance.
    task automatic push_desc(input bit inst, input int p, input s_dma_desc_t d,
                             output bit acc);
        int n;
        acc = 1'b0;
        n   = 0;
        req_desc[p] = d;
        if (inst) to_req_valid[p] = 1'b1; else req_valid[p] = 1'b1;
        while (!acc && n < 50) begin
            acc = inst ? to_ready[p] : ready[p];
            @(negedge clk);
            n++;
        end
        if (inst) to_req_valid[p] = 1'b0; else req_valid[p] = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        en           = 1'b0;
        req_valid    = '0;
        to_req_valid = '0;
        cpl_ready    = 1'b1;
        to_cpl_ready = 1'b1;
        dma_err_in   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        en           = 1'b0;
        req_valid    = '0;
        to_req_valid = '0;
        cpl_ready    = 1'b1;
        to_cpl_ready = 1'b1;
        dma_err_in   = '0;
        req_desc     = '0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({go, mctrl, cpl_valid, busy, ready} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b expected 000000", {go, mctrl, cpl_valid, busy, ready});
        end
        compared++;
        if ({desc_out, cpl} !== '0) begin
            mismatched++;
            $display("FAIL reset_regs: got desc %h cpl %h expected 0", desc_out, cpl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (ready !== 2'b11) begin
            mismatched++;
            $display("FAIL reset_ready: got %b expected 11", ready);
        end
    endtask

    task automatic test_single();
        s_dma_desc_t d;
        bit acc;
        int cyc, gos, mc;
        apply_reset();
        en         = 1'b1;
        done_delay = 20;
        cpl_ready  = 1'b0;
        d = mk(32'h1100_011b, 32'h1400_0127, 32'h0000_000b);
        push_desc(1'b0, 0, d, acc);
        wait_for(0, 20, cyc);
        compared++;
        if (!acc || cyc !== 1) begin
            mismatched++;
            $display("FAIL single_latency: got acc %0d go after %0d cycles expected 1", acc, cyc);
        end
        gos = 0;
        mc  = 0;
        for (int i = 0; i < 100; i++) begin
            if (cpl_valid) break;
            gos += int'(go);
            mc  += int'(mctrl);
            @(negedge clk);
        end
        compared++;
        if (gos !== 1) begin
            mismatched++;
            $display("FAIL single_go_pulses: got %0d expected 1", gos);
        end
        compared++;
        if (mc !== 21) begin
            mismatched++;
            $display("FAIL single_master_ctrl: got %0d cycles expected 21", mc);
        end
        compared++;
        if (desc_out !== d) begin
            mismatched++;
            $display("FAIL single_desc: got %h expected %h", desc_out, d);
        end
        compared++;
        if ({cpl_valid, cpl.req_id, cpl.err, cpl.timeout, cpl.skipped} !== 5'b10000) begin
            mismatched++;
            $display("FAIL single_cpl: got %b expected 10000",
                     {cpl_valid, cpl.req_id, cpl.err, cpl.timeout, cpl.skipped});
        end
        repeat (3) @(negedge clk);
        compared++;
        if ({cpl_valid, mctrl, busy} !== 3'b101) begin
            mismatched++;
            $display("FAIL single_cpl_hold: got %b expected 101", {cpl_valid, mctrl, busy});
        end
        cpl_ready = 1'b1;
        @(negedge clk);
        compared++;
        if ({cpl_valid, busy} !== 2'b00) begin
            mismatched++;
            $display("FAIL single_handshake: got %b expected 00", {cpl_valid, busy});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic        exp_id;
        logic [31:0] exp_src;
        apply_reset();
        done_delay = 5;
        for (int i = 0; i < 3; i++) begin
            req_desc[0] = mk(32'h1000_0000 + 32'(i), 32'h5000_0000, 32'h10);
            req_desc[1] = mk(32'h2000_0000 + 32'(i), 32'h6000_0000, 32'h20);
            req_valid   = 2'b11;
            @(negedge clk);
        end
        req_valid = '0;
        compared++;
        if ({busy, ready} !== 3'b011) begin
            mismatched++;
            $display("FAIL b2b_stalled: got %b expected 011", {busy, ready});
        end
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_id  = 1'(k % 2);
            exp_src = (exp_id ? 32'h2000_0000 : 32'h1000_0000) + 32'(k / 2);
            wait_for(1, 100, cyc);
            compared++;
            if (cyc < 0 || {cpl.req_id, cpl.err, cpl.timeout, cpl.skipped, desc_out.src_addr}
                           !== {exp_id, 3'b000, exp_src}) begin
                mismatched++;
                $display("FAIL b2b_order_%0d: got id %b flags %b src %h expected id %b flags 000 src %h",
                         k, cpl.req_id, {cpl.err, cpl.timeout, cpl.skipped}, desc_out.src_addr,
                         exp_id, exp_src);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full();
        bit acc;
        int n, cyc;
        apply_reset();
        done_delay = 3;
        for (int i = 0; i < 4; i++) begin
            push_desc(1'b0, 1, mk(32'h4000_0000 + 32'(i), 32'h7000_0000, 32'h40), acc);
        end
        compared++;
        if (!acc || ready !== 2'b01) begin
            mismatched++;
            $display("FAIL full_ready_drop: got ready %b expected 01", ready);
        end
        req_desc[1]  = mk(32'h4000_0004, 32'h7000_0000, 32'h40);
        req_valid[1] = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({busy, ready} !== 3'b001) begin
            mismatched++;
            $display("FAIL full_hold: got %b expected 001", {busy, ready});
        end
        en = 1'b1;
        n  = 0;
        while (!ready[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        compared++;
        if (n !== 1) begin
            mismatched++;
            $display("FAIL full_fifth_accept: got ready after %0d cycles expected 1", n);
        end
        for (int k = 0; k < 5; k++) begin
            wait_for(1, 100, cyc);
            compared++;
            if (cyc < 0 || {cpl.req_id, desc_out.src_addr} !== {1'b1, 32'h4000_0000 + 32'(k)}) begin
                mismatched++;
                $display("FAIL full_cpl_%0d: got id %b src %h expected id 1 src %h",
                         k, cpl.req_id, desc_out.src_addr, 32'h4000_0000 + 32'(k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_skip();
        bit acc;
        int cyc;
        logic seen;
        apply_reset();
        en        = 1'b1;
        cpl_ready = 1'b0;
        push_desc(1'b0, 0, mk(32'h3000_0000, 32'h3100_0000, 32'h0), acc);
        cyc  = -1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | go | mctrl;
            if (cpl_valid) begin
                cyc = i;
                break;
            end
            @(negedge clk);
        end
        compared++;
        if (!acc || cyc < 0 || cyc > 1) begin
            mismatched++;
            $display("FAIL skip_latency: got cpl after %0d cycles expected 1", cyc);
        end
        compared++;
        if (seen !== 1'b0) begin
            mismatched++;
            $display("FAIL skip_no_dma: got go|master_ctrl %b expected 0", seen);
        end
        compared++;
        if ({cpl.req_id, cpl.err, cpl.timeout, cpl.skipped} !== 4'b0001) begin
            mismatched++;
            $display("FAIL skip_cpl: got %b expected 0001",
                     {cpl.req_id, cpl.err, cpl.timeout, cpl.skipped});
        end
        cpl_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_error();
        bit acc;
        int cyc;
        s_dma_sched_cpl_t exp;
        apply_reset();
        en         = 1'b1;
        done_delay = 4;
        dma_err_in.err_addr = 32'hdead_beef;
        dma_err_in.err_src  = 1'b1;
        dma_err_in.err_dst  = 1'b0;
        exp.req_id   = 1'b1;
        exp.err      = 1'b1;
        exp.timeout  = 1'b0;
        exp.skipped  = 1'b0;
        exp.dma_err.err_addr = 32'hdead_beef;
        exp.dma_err.err_src  = 1'b1;
        exp.dma_err.err_dst  = 1'b0;
        push_desc(1'b0, 1, mk(32'h5500_0000, 32'h5600_0000, 32'h8), acc);
        wait_for(1, 100, cyc);
        compared++;
        if (!acc || cyc < 0 || cpl !== exp) begin
            mismatched++;
            $display("FAIL error_cpl: got %h expected %h", cpl, exp);
        end
        @(negedge clk);
        dma_err_in = '0;
    endtask

    task automatic test_timeout();
        bit acc_a, acc_b;
        int cyc, waits;
        apply_reset();
        en           = 1'b1;
        done_delay   = 0;
        to_cpl_ready = 1'b0;
        push_desc(1'b1, 0, mk(32'h6600_0000, 32'h6700_0000, 32'h10), acc_a);
        push_desc(1'b1, 1, mk(32'h6800_0000, 32'h6900_0000, 32'h10), acc_b);
        wait_for(2, 20, cyc);
        @(negedge clk);
        waits = 0;
        for (int i = 0; i < 100; i++) begin
            if (to_cpl_valid) break;
            waits += int'(to_mctrl);
            @(negedge clk);
        end
        compared++;
        if (!acc_a || !acc_b || cyc < 0 || waits !== 16) begin
            mismatched++;
            $display("FAIL timeout_wait_cycles: got %0d expected 16", waits);
        end
        compared++;
        if ({to_cpl_valid, to_cpl.req_id, to_cpl.err, to_cpl.timeout, to_cpl.skipped} !== 5'b10010) begin
            mismatched++;
            $display("FAIL timeout_cpl: got %b expected 10010",
                     {to_cpl_valid, to_cpl.req_id, to_cpl.err, to_cpl.timeout, to_cpl.skipped});
        end
        done_delay   = 5;
        to_cpl_ready = 1'b1;
        @(negedge clk);
        wait_for(3, 100, cyc);
        compared++;
        if (cyc < 0 || {to_cpl.req_id, to_cpl.err, to_cpl.timeout, to_cpl.skipped, to_desc_out.src_addr}
                       !== {4'b1000, 32'h6800_0000}) begin
            mismatched++;
            $display("FAIL timeout_next_launch: got id %b flags %b src %h expected id 1 flags 000 src 68000000",
                     to_cpl.req_id, {to_cpl.err, to_cpl.timeout, to_cpl.skipped}, to_desc_out.src_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit acc_a, acc_b;
        int cyc;
        logic seen;
        apply_reset();
        en         = 1'b1;
        done_delay = 0;
        push_desc(1'b0, 0, mk(32'h7700_0000, 32'h7800_0000, 32'h10), acc_a);
        wait_for(0, 20, cyc);
        push_desc(1'b0, 1, mk(32'h7900_0000, 32'h7a00_0000, 32'h10), acc_b);
        compared++;
        if (!acc_a || !acc_b || cyc < 0 || {mctrl, busy, cpl_valid} !== 3'b110) begin
            mismatched++;
            $display("FAIL reset_mid_wait: got %b expected 110", {mctrl, busy, cpl_valid});
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if ({go, mctrl, cpl_valid, busy, ready} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_mid_outputs: got %b expected 000000", {go, mctrl, cpl_valid, busy, ready});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (ready !== 2'b11) begin
            mismatched++;
            $display("FAIL reset_mid_ready: got %b expected 11", ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | go | busy | cpl_valid;
            @(negedge clk);
        end
        compared++;
        if (seen !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_quiet: got activity %b expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_skip();
        test_error();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
